// File: rtl/halt_dump_pkg.sv
// rtl/halt_dump_pkg.sv - shared types and encodings for the halt detector and memory dump sweep
package halt_dump_pkg;

    typedef enum logic [2:0] {
        MONITOR = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        CSUM    = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic [15:0] CNOP_ENC     = 16'h0001;
    localparam logic [31:0] ADDI_NOP_ENC = 32'h0000_0013;

    // Checksum beat address; the top slices it down to its console address width.
    localparam logic [31:0] CSUM_MARKER_ADDR = 32'hFFFF_FFFF;

    function automatic logic is_nop(input logic [31:0] i);
        return (i[15:0] == CNOP_ENC) || (i == ADDI_NOP_ENC);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/halt_dump_ctrl_halt_detect.sv
// rtl/halt_dump_ctrl_halt_detect.sv - detects NOP spin / stuck fetch and keeps cycle and NOP metrics
module halt_detect
    import halt_dump_pkg::*;
#(
    parameter int STALL_LIMIT = 49,
    parameter int NOP_LIMIT   = 16
) (
    input  logic        CLK100MHZ,
    input  logic        nrst,
    input  logic        monitor_en,
    input  logic [31:0] inst,
    output logic        halt_pulse,
    output logic [31:0] cycle_count,
    output logic [31:0] nop_count
);

    localparam int CNT_W = 16;

    logic [31:0]      last_inst_q, last_inst_d;
    logic [CNT_W-1:0] same_cnt_q, same_cnt_d;
    logic [CNT_W-1:0] nop_rep_q, nop_rep_d;
    logic [31:0]      cycle_count_q, cycle_count_d;
    logic [31:0]      nop_count_q, nop_count_d;
    logic             inst_nop;

    assign inst_nop = is_nop(inst);

    // Halt is judged on the registered counters, so the repeat that reaches the limit is already stored.
    assign halt_pulse = monitor_en &&
                        ((same_cnt_q == CNT_W'(STALL_LIMIT)) || (nop_rep_q == CNT_W'(NOP_LIMIT)));

    always_comb begin
        last_inst_d   = last_inst_q;
        same_cnt_d    = same_cnt_q;
        nop_rep_d     = nop_rep_q;
        cycle_count_d = cycle_count_q;
        nop_count_d   = nop_count_q;
        if (monitor_en && !halt_pulse) begin
            if (inst == last_inst_q) begin
                same_cnt_d = (same_cnt_q == '1) ? same_cnt_q : same_cnt_q + CNT_W'(1);
                if (inst_nop) begin
                    nop_rep_d = (nop_rep_q == '1) ? nop_rep_q : nop_rep_q + CNT_W'(1);
                end
            end else begin
                last_inst_d = inst;
                same_cnt_d  = '0;
                nop_rep_d   = '0;
            end
            cycle_count_d = sat_inc32(cycle_count_q);
            if (inst_nop) begin
                nop_count_d = sat_inc32(nop_count_q);
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!nrst) begin
            last_inst_q   <= '0;
            same_cnt_q    <= '0;
            nop_rep_q     <= '0;
            cycle_count_q <= '0;
            nop_count_q   <= '0;
        end else begin
            last_inst_q   <= last_inst_d;
            same_cnt_q    <= same_cnt_d;
            nop_rep_q     <= nop_rep_d;
            cycle_count_q <= cycle_count_d;
            nop_count_q   <= nop_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign nop_count   = nop_count_q;

endmodule

// File: rtl/halt_dump_ctrl.sv
// rtl/halt_dump_ctrl.sv - halt detection followed by a console-port memory dump stream
// Optional trailing checksum beat: define DUMP_CHECKSUM_EN.
module halt_dump_ctrl
    import halt_dump_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int MAX_ADDR    = 143,
    parameter int STALL_LIMIT = 49,
    parameter int NOP_LIMIT   = 16
) (
    input  logic              CLK100MHZ,
    input  logic              nrst,
    input  logic [31:0]       inst,
    output logic [ADDR_W-1:0] con_addr,
    input  logic [31:0]       con_out,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [31:0]       dump_data,
    output logic              dump_last,
    output logic              halted,
    output logic              done,
    output logic [31:0]       cycle_count,
    output logic [31:0]       nop_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);
`ifdef DUMP_CHECKSUM_EN
    localparam logic [ADDR_W-1:0] CSUM_ADDR = CSUM_MARKER_ADDR[ADDR_W-1:0];
`endif

    state_e            state_q, state_d;
    logic              halted_q, halted_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] con_addr_q, con_addr_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [31:0]       dump_data_q, dump_data_d;
    logic              dump_last_q, dump_last_d;
    logic              dump_valid_q, dump_valid_d;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    logic halt_pulse;
    logic hs;
    logic at_last;

    halt_detect #(
        .STALL_LIMIT(STALL_LIMIT),
        .NOP_LIMIT  (NOP_LIMIT)
    ) u_halt_detect (
        .CLK100MHZ  (CLK100MHZ),
        .nrst       (nrst),
        .monitor_en (state_q == MONITOR),
        .inst       (inst),
        .halt_pulse (halt_pulse),
        .cycle_count(cycle_count),
        .nop_count  (nop_count)
    );

    assign hs      = dump_valid_q && dump_ready;
    assign at_last = (dump_addr_q == LAST_ADDR);

    always_ff @(posedge CLK100MHZ) begin
        if (!nrst) begin
            state_q <= MONITOR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MONITOR: if (halt_pulse) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = SEND;
            SEND: begin
                if (hs) begin
`ifdef DUMP_CHECKSUM_EN
                    state_d = at_last ? CSUM : ISSUE;
`else
                    state_d = at_last ? DONE : ISSUE;
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM:    if (hs) state_d = DONE;
`endif
            DONE:    state_d = DONE;
            default: state_d = MONITOR;
        endcase
    end

    // Output register: the beat is latched at CAPTURE and held untouched until its handshake.
    always_comb begin
        halted_d     = halted_q;
        done_d       = done_q;
        con_addr_d   = con_addr_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        dump_last_d  = dump_last_q;
        dump_valid_d = dump_valid_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            MONITOR: begin
                if (halt_pulse) halted_d = 1'b1;
            end
            CAPTURE: begin
                dump_data_d  = con_out;
                dump_addr_d  = con_addr_q;
                dump_valid_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                dump_last_d  = 1'b0;
                csum_d       = csum_q + con_out;
`else
                dump_last_d  = (con_addr_q == LAST_ADDR);
`endif
            end
            SEND: begin
                if (hs) begin
                    dump_valid_d = 1'b0;
                    if (!at_last) begin
                        con_addr_d = con_addr_q + ADDR_W'(1);
                    end
`ifdef DUMP_CHECKSUM_EN
                    else begin
                        dump_addr_d  = CSUM_ADDR;
                        dump_data_d  = csum_q;
                        dump_last_d  = 1'b1;
                        dump_valid_d = 1'b1;
                    end
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                if (hs) dump_valid_d = 1'b0;
            end
`endif
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!nrst) begin
            halted_q     <= 1'b0;
            done_q       <= 1'b0;
            con_addr_q   <= '0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_last_q  <= 1'b0;
            dump_valid_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            halted_q     <= halted_d;
            done_q       <= done_d;
            con_addr_q   <= con_addr_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            dump_last_q  <= dump_last_d;
            dump_valid_q <= dump_valid_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign con_addr   = con_addr_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;
    assign dump_last  = dump_last_q;
    assign dump_valid = dump_valid_q;
    assign halted     = halted_q;
    assign done       = done_q;

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// tb/tb_halt_dump_ctrl.sv - directed vector bench for halt_dump_ctrl
module tb_halt_dump_ctrl;
    import halt_dump_pkg::*;

    localparam int ADDR_W   = 14;
    localparam int MAX_ADDR = 143;
`ifdef DUMP_CHECKSUM_EN
    localparam int EXP_BEATS = MAX_ADDR + 2;
`else
    localparam int EXP_BEATS = MAX_ADDR + 1;
`endif

    logic              CLK100MHZ = 1'b0;
    logic              nrst = 1'b0;
    logic [31:0]       inst = '0;
    logic [ADDR_W-1:0] con_addr;
    logic [31:0]       con_out = '0;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic [ADDR_W-1:0] dump_addr;
    logic [31:0]       dump_data;
    logic              dump_last;
    logic              halted;
    logic              done;
    logic [31:0]       cycle_count;
    logic [31:0]       nop_count;

    int n_vec = 0;
    int n_err = 0;

    halt_dump_ctrl #(
        .ADDR_W     (ADDR_W),
        .MAX_ADDR   (MAX_ADDR),
        .STALL_LIMIT(49),
        .NOP_LIMIT  (16)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .nrst       (nrst),
        .inst       (inst),
        .con_addr   (con_addr),
        .con_out    (con_out),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .halted     (halted),
        .done       (done),
        .cycle_count(cycle_count),
        .nop_count  (nop_count)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // Console memory model: mem[a] = a * 0x01010101, one cycle read latency.
    always @(posedge CLK100MHZ) con_out <= 32'(con_addr) * 32'h0101_0101;

    typedef struct {
        logic [31:0] spin;
        int          n_pre;
        logic        pre_nop;
        int          exp_cycles;
        int          exp_nops;
    } halt_vec_t;

    halt_vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] stim(input halt_vec_t v, input int k);
        if (k < v.n_pre) begin
            if (v.pre_nop) return {16'(k + 1), 16'h0001};
            return 32'h0000_0093 | (32'(k + 1) << 20);
        end
        return v.spin;
    endfunction

    task automatic do_reset(input logic [31:0] i);
        nrst = 1'b0;
        inst = i;
        repeat (2) @(posedge CLK100MHZ);
        #1 nrst = 1'b1;
    endtask

    task automatic run_halt(input halt_vec_t v, input int idx);
        dump_ready = 1'b0;
        do_reset(stim(v, 0));
        for (int k = 0; k <= v.exp_cycles; k++) begin
            @(posedge CLK100MHZ);
            #1;
            if (k == v.exp_cycles - 1) check($sformatf("v%0d halted_early", idx), 64'(halted), 64'd0);
            inst = stim(v, k + 1);
        end
        check($sformatf("v%0d halted", idx), 64'(halted), 64'd1);
        check($sformatf("v%0d cycle_count", idx), 64'(cycle_count), 64'(v.exp_cycles));
        check($sformatf("v%0d nop_count", idx), 64'(nop_count), 64'(v.exp_nops));
    endtask

    task automatic run_dump(input int bp_addr, input int abort_addr, output int beats, output logic aborted);
        logic [31:0] csum;
        logic [63:0] exp_beat;
        logic [31:0] exp_data;
        logic        finished;
        csum     = '0;
        beats    = 0;
        aborted  = 1'b0;
        finished = 1'b0;
        for (int a = 0; a <= MAX_ADDR; a++) csum += 32'(a) * 32'h0101_0101;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge CLK100MHZ);
            if (abort_addr >= 0 && dump_valid && dump_addr == ADDR_W'(abort_addr)) begin
                nrst = 1'b0;
                @(posedge CLK100MHZ);
                #1 nrst = 1'b1;
                aborted = 1'b1;
                return;
            end
            if (bp_addr >= 0 && dump_valid && dump_addr == ADDR_W'(bp_addr)) begin
                exp_data   = 32'(bp_addr) * 32'h0101_0101;
                dump_ready = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    @(negedge CLK100MHZ);
                    check("bp_hold", {dump_valid, con_addr, dump_addr, dump_data},
                          {1'b1, ADDR_W'(bp_addr), ADDR_W'(bp_addr), exp_data});
                end
                dump_ready = 1'b1;
                bp_addr    = -1;
            end
            if (dump_valid && dump_ready) begin
                if (beats <= MAX_ADDR)
                    exp_beat = {17'd0, ADDR_W'(beats), 32'(beats) * 32'h0101_0101,
                                (EXP_BEATS == MAX_ADDR + 1) && (beats == MAX_ADDR)};
                else
                    exp_beat = {17'd0, {ADDR_W{1'b1}}, csum, 1'b1};
                check($sformatf("beat%0d", beats), {17'd0, dump_addr, dump_data, dump_last}, exp_beat);
                beats++;
                if (dump_last || beats >= EXP_BEATS) finished = 1'b1;
            end
        end
        @(posedge CLK100MHZ);
        repeat (3) @(negedge CLK100MHZ);
        check("beat_count", 64'(beats), 64'(EXP_BEATS));
        check("done_state", {done, dump_valid, con_addr}, {1'b1, 1'b0, ADDR_W'(MAX_ADDR)});
        check("metrics_frozen", {cycle_count, nop_count}, {32'd50, 32'd0});
    endtask

    initial begin
        int   beats;
        logic aborted;

        vecs[0] = '{32'h0000_0013, 20, 1'b0, 37, 17};
        vecs[1] = '{32'h0000_006F, 0,  1'b0, 50, 0};
        vecs[2] = '{32'hABCD_0001, 5,  1'b0, 22, 17};
        vecs[3] = '{32'h0000_006F, 3,  1'b0, 53, 0};
        vecs[4] = '{32'h0000_0013, 10, 1'b1, 27, 27};

        repeat (3) @(posedge CLK100MHZ);
        #1;
        check("reset_outputs",
              {halted, done, dump_valid, dump_last, con_addr, dump_addr},
              64'd0);
        check("reset_data", {dump_data, cycle_count}, 64'd0);
        check("reset_nops", {32'd0, nop_count}, 64'd0);

        for (int i = 0; i < 5; i++) run_halt(vecs[i], i);

        dump_ready = 1'b1;
        do_reset(32'h0000_006F);
        run_dump(5, -1, beats, aborted);

        dump_ready = 1'b1;
        do_reset(32'h0000_006F);
        run_dump(-1, 70, beats, aborted);
        check("abort_seen", 64'(aborted), 64'd1);
        check("abort_outputs",
              {halted, done, dump_valid, dump_last, con_addr, dump_addr},
              64'd0);
        check("abort_data_metrics", {dump_data, cycle_count}, 64'd0);
        check("abort_state", 64'(dut.state_q), 64'(MONITOR));
        run_dump(-1, -1, beats, aborted);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
